// File: rtl/boot_sequencer.sv
// -----------------------------------------------------------------------------
// boot_sequencer
//   Downloads a framed program image from the UART byte receiver into program
//   memory. Frame: MAGIC, 16-bit word count (low byte first), little-endian
//   payload words, then an 8-bit modulo-256 checksum of the payload bytes.
//   Each completed word is written through a ready/valid write port. The core
//   is held in reset until a frame verifies, then released to run.
//
// Ports
//   clk, reset_n          clock / asynchronous active-low reset
//   rx_data, rx_valid     received byte and its one-cycle strobe
//   start, abort          arm the loader / cancel back to IDLE (abort wins)
//   pmem_addr/wdata/we    write request, held until pmem_ready accepts it
//   pmem_ready            write accept
//   core_reset, core_run  core control
//   busy                  frame in progress
//   err_code              0 none,1 magic,2 length,3 checksum,4 timeout,5 overrun
//   words_written         accepted writes in the current frame
// -----------------------------------------------------------------------------
module boot_sequencer #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
    parameter int unsigned       MAX_WORDS = 32'd16384,
    parameter logic [7:0]        MAGIC     = 8'hA5,
    parameter int unsigned       TIMEOUT   = 32'd50000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [31:0]       pmem_wdata,
    output logic              pmem_we,
    input  logic              pmem_ready,
    output logic              core_reset,
    output logic              core_run,
    output logic              busy,
    output logic [2:0]        err_code,
    output logic [15:0]       words_written
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 32'd1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HDR_MAGIC = 3'd1,
        S_HDR_LEN_L = 3'd2,
        S_HDR_LEN_H = 3'd3,
        S_PAYLOAD   = 3'd4,
        S_CHECK     = 3'd5,
        S_RUN       = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [2:0]         w_err_nxt;
    logic [15:0]        r_len, w_len_nxt;
    logic [1:0]         r_byte_idx, w_byte_idx_nxt;
    logic [15:0]        r_word_idx, w_word_idx_nxt;
    logic [7:0]         r_csum, w_csum_nxt;
    logic [23:0]        r_asm, w_asm_nxt;
    logic [TMO_W-1:0]   r_tmo, w_tmo_nxt;
    logic [ADDR_W-1:0]  r_pmem_addr, w_addr_nxt;
    logic [31:0]        r_pmem_wdata, w_wdata_nxt;
    logic               r_pmem_we, w_we_nxt;
    logic               r_core_reset, r_core_run, r_busy;
    logic [2:0]         r_err_code;
    logic [15:0]        r_words_written, w_words_nxt;

    logic               w_start_ok, w_pay_byte, w_word_done, w_accept;
    logic               w_last_acc, w_tmo_run, w_tmo_exp, w_len_bad;
    logic [15:0]        w_len_full;

    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_ERROR));
    // Once every word has been assembled, further bytes before the final write
    // is accepted are not payload and are dropped.
    assign w_pay_byte  = (r_state == S_PAYLOAD) && rx_valid && (r_word_idx != r_len);
    assign w_word_done = w_pay_byte && (r_byte_idx == 2'd3);
    assign w_accept    = r_pmem_we && pmem_ready;
    assign w_last_acc  = (r_state == S_PAYLOAD) && w_accept && ((r_words_written + 16'd1) == r_len);
    assign w_tmo_run   = (r_state == S_HDR_LEN_L) || (r_state == S_HDR_LEN_H) ||
                         (r_state == S_PAYLOAD)   || (r_state == S_CHECK);
    // A byte arriving in the expiry cycle takes precedence over the timeout.
    assign w_tmo_exp   = w_tmo_run && !rx_valid && (r_tmo == TMO_W'(TIMEOUT - 32'd1));
    assign w_len_full  = {rx_data, r_len[7:0]};
    assign w_len_bad   = (w_len_full == 16'd0) || ({16'd0, w_len_full} > MAX_WORDS);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and error-code selection.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err_code;
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 3'd0;
        end else if (w_start_ok) begin
            w_state_nxt = S_HDR_MAGIC;
            w_err_nxt   = 3'd0;
        end else begin
            case (r_state)
                S_HDR_MAGIC: begin
                    if (rx_valid && (rx_data == MAGIC)) begin
                        w_state_nxt = S_HDR_LEN_L;
                    end else if (rx_valid) begin
                        w_state_nxt = S_ERROR;
                        w_err_nxt   = 3'd1;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                S_HDR_LEN_L: begin
                    if (rx_valid) begin
                        w_state_nxt = S_HDR_LEN_H;
                    end else if (w_tmo_exp) begin
                        w_state_nxt = S_ERROR;
                        w_err_nxt   = 3'd4;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                S_HDR_LEN_H: begin
                    if (rx_valid && w_len_bad) begin
                        w_state_nxt = S_ERROR;
                        w_err_nxt   = 3'd2;
                    end else if (rx_valid) begin
                        w_state_nxt = S_PAYLOAD;
                    end else if (w_tmo_exp) begin
                        w_state_nxt = S_ERROR;
                        w_err_nxt   = 3'd4;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                S_PAYLOAD: begin
                    if (w_word_done && r_pmem_we) begin
                        w_state_nxt = S_ERROR;
                        w_err_nxt   = 3'd5;
                    end else if (w_last_acc) begin
                        w_state_nxt = S_CHECK;
                    end else if (w_tmo_exp) begin
                        w_state_nxt = S_ERROR;
                        w_err_nxt   = 3'd4;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                S_CHECK: begin
                    if (rx_valid && (rx_data == r_csum)) begin
                        w_state_nxt = S_RUN;
                    end else if (rx_valid) begin
                        w_state_nxt = S_ERROR;
                        w_err_nxt   = 3'd3;
                    end else if (w_tmo_exp) begin
                        w_state_nxt = S_ERROR;
                        w_err_nxt   = 3'd4;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                S_IDLE, S_RUN, S_ERROR: w_state_nxt = r_state;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Next values of the datapath and write-port registers.
    always_comb begin
        w_len_nxt      = r_len;
        w_byte_idx_nxt = r_byte_idx;
        w_word_idx_nxt = r_word_idx;
        w_csum_nxt     = r_csum;
        w_asm_nxt      = r_asm;
        w_tmo_nxt      = r_tmo;
        w_addr_nxt     = r_pmem_addr;
        w_wdata_nxt    = r_pmem_wdata;
        w_we_nxt       = r_pmem_we;
        w_words_nxt    = r_words_written;
        if (abort) begin
            // A pending write is dropped.
            w_we_nxt = 1'b0;
        end else if (w_start_ok) begin
            w_byte_idx_nxt = 2'd0;
            w_word_idx_nxt = 16'd0;
            w_csum_nxt     = 8'd0;
            w_tmo_nxt      = {TMO_W{1'b0}};
            w_words_nxt    = 16'd0;
            w_we_nxt       = 1'b0;
        end else begin
            if ((r_state == S_HDR_LEN_L) && rx_valid) begin
                w_len_nxt[7:0] = rx_data;
            end else if ((r_state == S_HDR_LEN_H) && rx_valid) begin
                w_len_nxt[15:8] = rx_data;
            end else begin
                w_len_nxt = r_len;
            end

            if (w_pay_byte) begin
                w_csum_nxt     = r_csum + rx_data;
                w_byte_idx_nxt = r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0: w_asm_nxt[7:0]   = rx_data;
                    2'd1: w_asm_nxt[15:8]  = rx_data;
                    2'd2: w_asm_nxt[23:16] = rx_data;
                    2'd3: begin
                        w_wdata_nxt    = {rx_data, r_asm};
                        w_addr_nxt     = BASE_ADDR + ADDR_W'({r_word_idx, 2'b00});
                        w_word_idx_nxt = r_word_idx + 16'd1;
                    end
                    default: w_asm_nxt = r_asm;
                endcase
            end else begin
                w_csum_nxt = r_csum;
            end

            if (w_state_nxt == S_ERROR) begin
                w_we_nxt = 1'b0;
            end else if (w_word_done) begin
                w_we_nxt = 1'b1;
            end else if (w_accept) begin
                w_we_nxt = 1'b0;
            end else begin
                w_we_nxt = r_pmem_we;
            end

            if (w_accept) begin
                w_words_nxt = r_words_written + 16'd1;
            end else begin
                w_words_nxt = r_words_written;
            end

            if (rx_valid) begin
                w_tmo_nxt = {TMO_W{1'b0}};
            end else if (w_tmo_run) begin
                w_tmo_nxt = r_tmo + TMO_W'(1);
            end else begin
                w_tmo_nxt = {TMO_W{1'b0}};
            end
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len           <= 16'd0;
            r_byte_idx      <= 2'd0;
            r_word_idx      <= 16'd0;
            r_csum          <= 8'd0;
            r_asm           <= 24'd0;
            r_tmo           <= {TMO_W{1'b0}};
            r_pmem_addr     <= {ADDR_W{1'b0}};
            r_pmem_wdata    <= 32'd0;
            r_pmem_we       <= 1'b0;
            r_words_written <= 16'd0;
            r_err_code      <= 3'd0;
            r_core_reset    <= 1'b1;
            r_core_run      <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_len           <= w_len_nxt;
            r_byte_idx      <= w_byte_idx_nxt;
            r_word_idx      <= w_word_idx_nxt;
            r_csum          <= w_csum_nxt;
            r_asm           <= w_asm_nxt;
            r_tmo           <= w_tmo_nxt;
            r_pmem_addr     <= w_addr_nxt;
            r_pmem_wdata    <= w_wdata_nxt;
            r_pmem_we       <= w_we_nxt;
            r_words_written <= w_words_nxt;
            r_err_code      <= w_err_nxt;
            r_core_reset    <= (w_state_nxt != S_RUN);
            r_core_run      <= (w_state_nxt == S_RUN);
            r_busy          <= (w_state_nxt == S_HDR_MAGIC) || (w_state_nxt == S_HDR_LEN_L) ||
                               (w_state_nxt == S_HDR_LEN_H) || (w_state_nxt == S_PAYLOAD) ||
                               (w_state_nxt == S_CHECK);
        end
    end

    assign pmem_addr     = r_pmem_addr;
    assign pmem_wdata    = r_pmem_wdata;
    assign pmem_we       = r_pmem_we;
    assign core_reset    = r_core_reset;
    assign core_run      = r_core_run;
    assign busy          = r_busy;
    assign err_code      = r_err_code;
    assign words_written = r_words_written;

endmodule

// File: tb/tb_boot_sequencer.sv
module tb_boot_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        pmem_ready = 1'b1;
    logic [31:0] pmem_addr;
    logic [31:0] pmem_wdata;
    logic        pmem_we;
    logic        core_reset;
    logic        core_run;
    logic        busy;
    logic [2:0]  err_code;
    logic [15:0] words_written;

    int          n_checks = 0;
    int          n_errors = 0;
    int          we_cycles = 0;
    logic [63:0] sb_q[$];
    logic [7:0]  good_f[12];

    boot_sequencer #(.TIMEOUT(32'd100)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .start(start), .abort(abort), .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
        .pmem_we(pmem_we), .pmem_ready(pmem_ready), .core_reset(core_reset),
        .core_run(core_run), .busy(busy), .err_code(err_code), .words_written(words_written)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted write must match the next expected one.
    always @(negedge clk) begin
        logic [63:0] exp_w;
        if (pmem_we) we_cycles++;
        if (reset_n && pmem_we && pmem_ready) begin
            if (sb_q.size() > 0) exp_w = sb_q.pop_front();
            else exp_w = 64'hDEAD_BEEF_DEAD_BEEF;
            check_eq("pmem_write", {pmem_addr, pmem_wdata}, exp_w);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drives one byte; returns 1 time unit after the edge that samples it.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Sends good_f[first..last] with idle gaps between bytes.
    task automatic send_range(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            send_byte(good_f[i]);
            idle(3);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_good();
        sb_q.push_back({32'h0000_0000, 32'h0000_0013});
        sb_q.push_back({32'h0000_0004, 32'h0010_0093});
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_we"},    64'(pmem_we),       64'd0);
        check_eq({tag, "_addr"},  64'(pmem_addr),     64'd0);
        check_eq({tag, "_wdata"}, 64'(pmem_wdata),    64'd0);
        check_eq({tag, "_creset"},64'(core_reset),    64'd1);
        check_eq({tag, "_crun"},  64'(core_run),      64'd0);
        check_eq({tag, "_busy"},  64'(busy),          64'd0);
        check_eq({tag, "_err"},   64'(err_code),      64'd0);
        check_eq({tag, "_ww"},    64'(words_written), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int base_we;
        int got_k;
        good_f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                   8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};

        // Reset state
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Good frame, with write-latency check on word 0
        push_good();
        pulse_start();
        @(negedge clk);
        check_eq("start_busy", 64'(busy), 64'd1);
        tick();
        send_range(0, 5);
        send_byte(good_f[6]);
        @(negedge clk);
        check_eq("w0_we_latency", 64'(pmem_we), 64'd1);
        check_eq("w0_addr", 64'(pmem_addr), 64'h0);
        check_eq("w0_data", 64'(pmem_wdata), 64'h13);
        tick();
        idle(3);
        send_range(7, 10);
        send_byte(8'hB6);
        @(negedge clk);
        check_eq("good_run", 64'(core_run), 64'd1);
        check_eq("good_creset", 64'(core_reset), 64'd0);
        check_eq("good_ww", 64'(words_written), 64'd2);
        check_eq("good_err", 64'(err_code), 64'd0);
        check_eq("good_busy", 64'(busy), 64'd0);
        check_eq("good_sb_empty", 64'(sb_q.size()), 64'd0);
        tick();

        // Bad magic: no write strobe at all
        base_we = we_cycles;
        pulse_start();
        send_byte(8'h5A);
        @(negedge clk);
        check_eq("magic_err", 64'(err_code), 64'd1);
        check_eq("magic_creset", 64'(core_reset), 64'd1);
        tick();
        idle(3);
        check_eq("magic_no_we", 64'(we_cycles - base_we), 64'd0);

        // Zero length
        pulse_start();
        send_range(0, 0);
        send_byte(8'h00);
        idle(3);
        send_byte(8'h00);
        @(negedge clk);
        check_eq("len_err", 64'(err_code), 64'd2);
        tick();

        // Bad checksum
        push_good();
        pulse_start();
        send_range(0, 10);
        send_byte(8'hB7);
        @(negedge clk);
        check_eq("csum_err", 64'(err_code), 64'd3);
        check_eq("csum_creset", 64'(core_reset), 64'd1);
        check_eq("csum_crun", 64'(core_run), 64'd0);
        check_eq("csum_ww", 64'(words_written), 64'd2);
        check_eq("csum_sb_empty", 64'(sb_q.size()), 64'd0);
        tick();

        // Backpressure on word 0 for 6 cycles
        push_good();
        pulse_start();
        send_range(0, 5);
        pmem_ready = 1'b0;
        send_byte(good_f[6]);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("bp_we", 64'(pmem_we), 64'd1);
            check_eq("bp_addr", 64'(pmem_addr), 64'h0);
            check_eq("bp_data", 64'(pmem_wdata), 64'h13);
        end
        @(posedge clk);
        #1;
        pmem_ready = 1'b1;
        idle(3);
        check_eq("bp_ww0", 64'(words_written), 64'd1);
        send_range(7, 10);
        send_byte(8'hB6);
        @(negedge clk);
        check_eq("bp_run", 64'(core_run), 64'd1);
        check_eq("bp_ww", 64'(words_written), 64'd2);
        check_eq("bp_sb_empty", 64'(sb_q.size()), 64'd0);
        tick();

        // Overrun: word 0 never accepted, word 1 completes on top of it
        pmem_ready = 1'b0;
        pulse_start();
        send_range(0, 9);
        send_byte(good_f[10]);
        @(negedge clk);
        check_eq("ovr_err", 64'(err_code), 64'd5);
        check_eq("ovr_we", 64'(pmem_we), 64'd0);
        check_eq("ovr_busy", 64'(busy), 64'd0);
        tick();
        pmem_ready = 1'b1;

        // Timeout: stop after byte 5
        pulse_start();
        send_range(0, 3);
        send_byte(good_f[4]);
        got_k = 0;
        for (int k = 1; k <= 150; k++) begin
            tick();
            if (err_code == 3'd4) begin
                got_k = k;
                break;
            end
        end
        check_eq("tmo_cycles", 64'(got_k), 64'd100);
        check_eq("tmo_code", 64'(err_code), 64'd4);

        // Abort mid-header
        pulse_start();
        send_byte(8'hA5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_creset", 64'(core_reset), 64'd1);
        tick();

        // Reset in mid-payload with a write pending
        sb_q.push_back({32'h0000_0000, 32'h0000_0013});
        pulse_start();
        send_range(0, 6);
        pmem_ready = 1'b0;
        send_range(7, 9);
        send_byte(good_f[10]);
        @(negedge clk);
        check_eq("pre_rst_we", 64'(pmem_we), 64'd1);
        check_eq("pre_rst_ww", 64'(words_written), 64'd1);
        check_eq("pre_rst_addr", 64'(pmem_addr), 64'h4);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        pmem_ready = 1'b1;
        tick();
        check_eq("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
